// File: rtl/mem_ooo_responder.sv
// Memory-side responder: accepts tagged reads into per-ID slots and returns each
// after an LFSR-chosen delay, round-robin arbitrated, so responses come back out of order.
module mem_ooo_responder #(
  parameter int          MEM_SIZE = 16,
  parameter int          IDWIDTH  = 4,
  parameter int          AWIDTH   = 40,
  parameter int          DWIDTH   = 32,
  parameter int          DLY_W    = 4,
  parameter int          DELAY_EN = 1,
  parameter logic [31:0] SEED     = 32'h1d76993a
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_req_val,
  input  logic [AWIDTH-1:0]  mem_req_addr,
  input  logic [IDWIDTH-1:0] mem_req_ID,
  output logic               mem_rsp_val,
  output logic [IDWIDTH-1:0] mem_rsp_ID,
  output logic [DWIDTH-1:0]  mem_rsp_data,
  output logic [IDWIDTH:0]   busy_cnt,
  output logic               err_dup
);

  localparam logic [31:0] POLY      = 32'h80200003;
  localparam logic [31:0] SEED_INIT = (SEED == 32'd0) ? 32'd1 : SEED;

  logic [MEM_SIZE-1:0] valid_reg;
  logic [MEM_SIZE-1:0] valid_next;
  logic [DLY_W-1:0]    cnt_reg  [MEM_SIZE];
  logic [DLY_W-1:0]    cnt_next [MEM_SIZE];
  logic [AWIDTH-1:0]   addr_reg [MEM_SIZE];
  logic [MEM_SIZE-1:0] eligible;

  logic [IDWIDTH-1:0]  ptr_reg;
  logic [31:0]         lfsr_reg;
  logic [31:0]         lfsr_next;
  logic                rsp_val_reg;
  logic [IDWIDTH-1:0]  rsp_id_reg;
  logic [DWIDTH-1:0]   rsp_data_reg;
  logic [IDWIDTH:0]    busy_cnt_reg;
  logic                err_dup_reg;

  logic                accept;
  logic                dup;
  logic [DLY_W-1:0]    delay;
  logic                grant_val;
  logic [IDWIDTH-1:0]  grant_id;
  logic [IDWIDTH-1:0]  arb_idx;
  logic [AWIDTH-1:0]   grant_addr;
  logic [DWIDTH-1:0]   grant_data;
  logic                unused_addr;

  assign accept    = mem_req_val & ~valid_reg[mem_req_ID];
  assign dup       = mem_req_val &  valid_reg[mem_req_ID];
  // Delay is drawn from the LFSR value before it advances for this request.
  assign delay     = (DELAY_EN != 0) ? lfsr_reg[DLY_W-1:0] : '0;
  assign lfsr_next = {1'b0, lfsr_reg[31:1]} ^ (lfsr_reg[0] ? POLY : 32'd0);

  for (genvar gi = 0; gi < MEM_SIZE; gi++) begin : g_slot
    logic hit_acc;
    logic hit_grant;
    assign hit_acc       = accept && (mem_req_ID == IDWIDTH'(gi));
    assign hit_grant     = grant_val && (grant_id == IDWIDTH'(gi));
    assign eligible[gi]  = valid_reg[gi] && (cnt_reg[gi] == '0);
    assign valid_next[gi] = hit_acc ? 1'b1 : (hit_grant ? 1'b0 : valid_reg[gi]);
    assign cnt_next[gi]  = hit_acc ? delay :
                           ((valid_reg[gi] && (cnt_reg[gi] != '0)) ? cnt_reg[gi] - 1'b1 : cnt_reg[gi]);
  end

  // Round-robin: first eligible slot at or after ptr, wrapping naturally in IDWIDTH bits.
  always_comb begin
    grant_val = 1'b0;
    grant_id  = '0;
    arb_idx   = '0;
    for (int i = 0; i < MEM_SIZE; i++) begin
      arb_idx = ptr_reg + IDWIDTH'(i);
      if (!grant_val && eligible[arb_idx]) begin
        grant_val = 1'b1;
        grant_id  = arb_idx;
      end
    end
  end

  assign grant_addr  = addr_reg[grant_id];
  assign unused_addr = ^grant_addr;

  if (AWIDTH >= DWIDTH) begin : g_trunc
    assign grant_data = grant_addr[DWIDTH-1:0];
  end else begin : g_zext
    assign grant_data = {{(DWIDTH-AWIDTH){1'b0}}, grant_addr};
  end

  always_ff @(posedge clk) begin
    if (accept) addr_reg[mem_req_ID] <= mem_req_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg    <= '0;
      for (int i = 0; i < MEM_SIZE; i++) cnt_reg[i] <= '0;
      ptr_reg      <= '0;
      lfsr_reg     <= SEED_INIT;
      rsp_val_reg  <= 1'b0;
      rsp_id_reg   <= '0;
      rsp_data_reg <= '0;
      busy_cnt_reg <= '0;
      err_dup_reg  <= 1'b0;
    end else begin
      valid_reg    <= valid_next;
      for (int i = 0; i < MEM_SIZE; i++) cnt_reg[i] <= cnt_next[i];
      rsp_val_reg  <= grant_val;
      if (grant_val) begin
        ptr_reg      <= grant_id + 1'b1;
        rsp_id_reg   <= grant_id;
        rsp_data_reg <= grant_data;
      end
      if (accept) lfsr_reg <= lfsr_next;
      if (accept && !grant_val)      busy_cnt_reg <= busy_cnt_reg + 1'b1;
      else if (!accept && grant_val) busy_cnt_reg <= busy_cnt_reg - 1'b1;
      if (dup) err_dup_reg <= 1'b1;
    end
  end

  assign mem_rsp_val  = rsp_val_reg;
  assign mem_rsp_ID   = rsp_id_reg;
  assign mem_rsp_data = rsp_data_reg;
  assign busy_cnt     = busy_cnt_reg;
  assign err_dup      = err_dup_reg;

endmodule

// File: tb/tb_mem_ooo_responder.sv
// Bench for mem_ooo_responder: a zero-delay and an LFSR-delay instance share one
// stimulus stream and are each compared every cycle against a pending-slot model.
module tb_mem_ooo_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_val;
  logic [39:0] req_addr;
  logic [3:0]  req_id;
  logic        rv0, rv1, ed0, ed1;
  logic [3:0]  rid0, rid1;
  logic [31:0] rd0, rd1;
  logic [4:0]  bc0, bc1;

  always #5 clk = ~clk;

  mem_ooo_responder #(.DELAY_EN(0)) dut0 (
    .clk(clk), .rst(rst), .mem_req_val(req_val), .mem_req_addr(req_addr), .mem_req_ID(req_id),
    .mem_rsp_val(rv0), .mem_rsp_ID(rid0), .mem_rsp_data(rd0), .busy_cnt(bc0), .err_dup(ed0)
  );

  mem_ooo_responder #(.DELAY_EN(1)) dut1 (
    .clk(clk), .rst(rst), .mem_req_val(req_val), .mem_req_addr(req_addr), .mem_req_ID(req_id),
    .mem_rsp_val(rv1), .mem_rsp_ID(rid1), .mem_rsp_data(rd1), .busy_cnt(bc1), .err_dup(ed1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: a slot is pending from acceptance until granted; it becomes eligible
  // one cycle after acceptance plus its drawn delay.
  bit          m_pend  [2][16];
  logic [39:0] m_addr  [2][16];
  int          m_ready [2][16];
  int          m_iss   [2][16];
  logic [31:0] m_lfsr  [2];
  int          m_ptr   [2];
  bit          m_err   [2];
  bit          e_val   [2];
  int          e_id    [2];
  logic [31:0] e_data  [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_adv(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h80200003 : 32'h0);
  endfunction

  task automatic model_update(input int k, input bit v, input int id, input logic [39:0] a);
    int g;
    int d;
    if (rst) begin
      for (int s = 0; s < 16; s++) m_pend[k][s] = 0;
      m_lfsr[k] = 32'h1d76993a;
      m_ptr[k]  = 0;
      m_err[k]  = 0;
      e_val[k]  = 0;
      e_id[k]   = 0;
      e_data[k] = 0;
      return;
    end
    g = -1;
    for (int i = 0; i < 16; i++) begin
      int s;
      s = (m_ptr[k] + i) % 16;
      if (g < 0 && m_pend[k][s] && cyc >= m_ready[k][s]) g = s;
    end
    if (v) begin
      if (m_pend[k][id]) m_err[k] = 1;
      else begin
        d = (k == 1) ? int'(m_lfsr[k][3:0]) : 0;
        m_pend[k][id]  = 1;
        m_addr[k][id]  = a;
        m_ready[k][id] = cyc + 1 + d;
        m_iss[k][id]   = cyc;
        m_lfsr[k]      = lfsr_adv(m_lfsr[k]);
      end
    end
    e_val[k] = (g >= 0);
    if (g >= 0) begin
      m_pend[k][g] = 0;
      m_ptr[k]     = (g + 1) % 16;
      e_id[k]      = g;
      e_data[k]    = m_addr[k][g][31:0];
      check($sformatf("latency_bound%0d", k), 64'(cyc + 1 - m_iss[k][g] <= 32), 64'd1);
    end
  endtask

  task automatic compare_outputs();
    for (int k = 0; k < 2; k++) begin
      int busy;
      busy = 0;
      for (int s = 0; s < 16; s++) busy += int'(m_pend[k][s]);
      check($sformatf("rsp_val%0d", k), 64'(k ? rv1 : rv0), 64'(e_val[k]));
      check($sformatf("busy_cnt%0d", k), 64'(k ? bc1 : bc0), 64'(busy));
      check($sformatf("err_dup%0d", k), 64'(k ? ed1 : ed0), 64'(m_err[k]));
      if (e_val[k]) begin
        check($sformatf("rsp_id%0d", k), 64'(k ? rid1 : rid0), 64'(e_id[k]));
        check($sformatf("rsp_data%0d", k), 64'(k ? rd1 : rd0), 64'(e_data[k]));
      end
    end
  endtask

  task automatic step(input bit v, input int id, input logic [39:0] a);
    req_val  = v;
    req_id   = 4'(id);
    req_addr = a;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_update(k, v, id, a);
    cyc++;
    #1;
    compare_outputs();
    if (v) $display("cyc %0d req id=%0d addr=%010h rsp0=%0b/%0d rsp1=%0b/%0d", cyc - 1, id, a, rv0, rid0, rv1, rid1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 40'h0);
  endtask

  initial begin
    rst = 1'b1; req_val = 1'b0; req_id = '0; req_addr = '0;
    idle(3);
    rst = 1'b0;
    while (cyc < 10) idle(1);

    // Directed single request with fixed expectations on the zero-delay instance.
    step(1'b1, 3, 40'h12_3456_789A);
    check("dir_busy_up", 64'(bc0), 64'd1);
    idle(1);
    check("dir_val", 64'(rv0), 64'd1);
    check("dir_id", 64'(rid0), 64'd3);
    check("dir_data", 64'(rd0), 64'h3456_789A);
    idle(1);
    check("dir_busy_down", 64'(bc0), 64'd0);
    idle(20);

    for (int i = 0; i < 16; i++) step(1'b1, i, 40'(i));
    idle(40);

    for (int i = 0; i < 16; i++) step(1'b1, i, 40'(i + 100));
    idle(60);

    step(1'b1, 5, 40'h555);
    step(1'b1, 5, 40'h999);
    idle(40);
    check("err_sticky", 64'(ed0), 64'd1);

    repeat (600) step(1'(($urandom() % 3) == 0), int'($urandom_range(0, 15)), {8'($urandom()), $urandom()});
    idle(60);

    // Reset with eight requests outstanding.
    for (int i = 0; i < 8; i++) step(1'b1, i * 2, 40'(i + 7));
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(50);
    check("post_rst_busy", 64'(bc0), 64'd0);
    check("post_rst_err", 64'(ed0), 64'd0);
    step(1'b1, 0, 40'hABC);
    idle(20);

    // Contention from ptr=0 with no delay.
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    step(1'b1, 2, 40'd2);
    step(1'b1, 9, 40'd9);
    check("cont_first", 64'(rid0), 64'd2);
    step(1'b1, 14, 40'd14);
    check("cont_second", 64'(rid0), 64'd9);
    idle(1);
    check("cont_third", 64'(rid0), 64'd14);
    check("cont_third_val", 64'(rv0), 64'd1);
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ooo_responder.md
# mem_ooo_responder

Memory-side responder for the reorder buffer's memory interface. It accepts tagged read requests (`mem_req_*`) with no back-pressure and holds up to `MEM_SIZE` outstanding requests, one slot per ID. It returns each response after a pseudo-random delay, so responses come back out of order. Response data is the request address truncated or zero-extended to `DWIDTH`, which lets benches check returned data directly against the address.

## Interface
- `MEM_SIZE`, 16, number of slots; must equal `2**IDWIDTH`
- `IDWIDTH`, 4, request/response tag width
- `AWIDTH`, 40, address width
- `DWIDTH`, 32, data width
- `DLY_W`, 4, width of per-slot delay counter; max extra delay `2**DLY_W-1`
- `DELAY_EN`, 1, 0 forces all delays to 0
- `SEED`, 32'h1d76993a, LFSR seed; a value of 0 is replaced by 1

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset; one clock domain, synchronous, active-high
- `mem_req_val`  in  1  request strobe, one request per cycle, always accepted
- `mem_req_addr`  in  AWIDTH  request address
- `mem_req_ID`  in  IDWIDTH  request tag = slot index
- `mem_rsp_val`  out  1  response strobe, registered, no ready
- `mem_rsp_ID`  out  IDWIDTH  response tag, registered
- `mem_rsp_data`  out  DWIDTH  response data, registered
- `busy_cnt`  out  IDWIDTH+1  number of valid slots
- `err_dup`  out  1  sticky; set by a request to an already-valid slot

## Operation
- Per-slot state: `valid`, `addr[AWIDTH-1:0]`, `cnt[DLY_W-1:0]`.
- Delay source: 32-bit Galois LFSR, polynomial 0x80200003.
  - Advances once per accepted request.
  - Delay for a new request = `DELAY_EN ? lfsr[DLY_W-1:0] : 0`, using the pre-advance value.
- Accept: `mem_req_val` with `valid[ID]==0` sets `valid=1`, `addr=mem_req_addr`, `cnt=delay`.
- Duplicate: `mem_req_val` with `valid[ID]==1` sets `err_dup`. The request is dropped, the slot is unchanged and the LFSR does not advance.
- Countdown: every cycle, each valid slot with `cnt!=0` decrements by 1.
- Eligible slot: `valid & cnt==0`.
- Arbitration: round-robin over eligible slots, at most one grant per cycle.
  - Search starts at `ptr`, wrapping `MEM_SIZE-1 -> 0`.
  - On a grant to slot g: `ptr <= g+1` (mod `MEM_SIZE`), and `valid[g]` clears.
- Data: if `AWIDTH>=DWIDTH`, data = `addr[DWIDTH-1:0]`; otherwise data = `addr` zero-extended to `DWIDTH`.
- `busy_cnt`: +1 on accept, −1 on grant; a simultaneous accept and grant leaves it unchanged.
  - Range 0..`MEM_SIZE`, with no saturation logic needed.

## Timing
- Reset values: `mem_rsp_val=0`, `mem_rsp_ID=0`, `mem_rsp_data=0`, `busy_cnt=0`, `err_dup=0`.
- Reset also clears all `valid` and `cnt`, sets `ptr=0` and `lfsr=SEED` (or 1 if `SEED` is 0).
- Reset mid-operation: all pending requests are discarded and no response is issued for them.
- Latency: request in cycle N, uncontended, delay d → `mem_rsp_val` in cycle N+2+d.
  - Contention adds whole cycles.
- `mem_rsp_val` is a single-cycle pulse per response.
- Back-to-back responses on consecutive cycles are allowed.
- Slot granted in cycle N (response visible in N+1):
  - A request to the same ID in cycle N is a duplicate, because `valid` is still 1.
  - A request to that ID in cycle N+1 or later is legal.
- Accept and grant in the same cycle on different slots are both performed.
- Full (`busy_cnt==MEM_SIZE`): every request is a duplicate by construction.
- `err_dup` clears only on `rst`.

## Test plan
- Reset, `DELAY_EN=0`: request ID=3, addr=40'h12_3456_789A in cycle 10 → `mem_rsp_val` in cycle 12 with ID=3, data=32'h3456_789A; `busy_cnt` goes 0→1→0.
- `DELAY_EN=0`, requests to IDs 0..15 on consecutive cycles, addr=ID → 16 responses on consecutive cycles, IDs in order 0..15, data=ID, `busy_cnt` peaks ≤16, `err_dup=0`.
- `DELAY_EN=1`, fill all 16 slots, addr=ID+100 → all 16 responses arrive, each ID exactly once with data=ID+100.
  - Response order differs from issue order.
  - Every latency ≤ 2+15+15 cycles.
- Request ID=5, then a second request ID=5 before its response → `err_dup=1`, exactly one response for ID 5 carrying the first address; `err_dup` stays 1 until `rst`.
- 8 slots pending, assert `rst` for 1 cycle → no `mem_rsp_val` for 50 cycles afterward, `busy_cnt=0`, and a fresh ID=0 request then completes normally.
- Contention, `DELAY_EN=0`: IDs 2, 9, 14 issued in cycles N, N+1, N+2 with `ptr=0` → responses in cycles N+2, N+3, N+4 with ID order 2, 9, 14; `ptr` ends at 15.
